alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures the ALU output, RESP holds it until taken.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic w_grant0;
  logic w_grant1;
  logic w_rsp_ready;

  // A lone valid always wins; on a tie the requester not served last goes next.
  assign w_grant0    = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  assign req0_ready  = (r_state == IDLE) && w_grant0;
  assign req1_ready  = (r_state == IDLE) && w_grant1;
  assign busy        = (r_state != IDLE);

  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ctrl    = r_op;

  assign rsp0_valid  = (r_state == RESP) && !r_owner;
  assign rsp1_valid  = (r_state == RESP) &&  r_owner;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_zero   = r_zero;

  // NOTE: every register here, datapath included, is reset so the ALU sees
  // zero operands and no stale result can leak out after an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 3'b000;
      r_result     <= '0;
      r_zero       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on the pre-edge values, independent of statement order.
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_a     <= req0_a;
            r_b     <= req0_b;
            r_op    <= req0_op;
            r_owner <= 1'b0;
            r_state <= EXEC;
          end else if (w_grant1) begin
            r_a     <= req1_a;
            r_b     <= req1_b;
            r_op    <= req1_op;
            r_owner <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= alu_result;
          r_zero   <= alu_zero;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_last_grant <= r_owner;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU model closes the loop and
// each step checks handshakes, latency and results against hand-computed values.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_ctrl;
  logic             alu_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Shared ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_a << alu_b[4:0];
      3'b110: alu_result = alu_a >> alu_b[4:0];
      3'b111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req0(1'b0, '0, '0, 3'b000);
    set_req1(1'b0, '0, '0, 3'b000);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready_idle_rule", req0_ready, 1);
    check("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD on requester 0
    set_req0(1'b1, 32'd5, 32'd3, 3'b000);
    #1;
    check("add_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    check("add_exec_busy", busy, 1);
    check("add_exec_rsp0_valid", rsp0_valid, 0);
    check("add_exec_req0_ready", req0_ready, 0);
    check("add_alu_a_latched", alu_a, 32'd5);
    tick();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp1_valid", rsp1_valid, 0);
    check("add_result", rsp0_result, 32'd8);
    check("add_zero", rsp0_zero, 0);
    tick();
    check("add_busy_done", busy, 0);
    check("add_rsp0_valid_done", rsp0_valid, 0);

    // Zero flag via SUB on requester 1
    set_req1(1'b1, 32'd7, 32'd7, 3'b001);
    #1;
    check("sub_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("sub_rsp1_valid", rsp1_valid, 1);
    check("sub_rsp0_valid", rsp0_valid, 0);
    check("sub_result", rsp1_result, 32'd0);
    check("sub_zero", rsp1_zero, 1);
    check("sub_shared_result_port0", rsp0_result, 32'd0);
    tick();
    check("sub_busy_done", busy, 0);

    // Valid withdrawn before any edge: nothing accepted, operands untouched
    set_req1(1'b1, 32'h1234, 32'h1, 3'b000);
    #2;
    req1_valid = 1'b0;
    tick();
    check("withdraw_busy", busy, 0);
    check("withdraw_alu_a", alu_a, 32'd7);

    // Contention from reset: grants alternate starting with requester 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req0(1'b1, 32'd100, 32'd1, 3'b000);
    set_req1(1'b1, 32'd50, 32'd8, 3'b001);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_req0_ready", i), req0_ready, (i % 2 == 0));
      check($sformatf("cont%0d_req1_ready", i), req1_ready, (i % 2 == 1));
      tick();
      check($sformatf("cont%0d_exec_readies", i), {req0_ready, req1_ready}, 0);
      tick();
      check($sformatf("cont%0d_rsp0_valid", i), rsp0_valid, (i % 2 == 0));
      check($sformatf("cont%0d_rsp1_valid", i), rsp1_valid, (i % 2 == 1));
      check($sformatf("cont%0d_result", i), rsp0_result, (i % 2 == 0) ? 32'd101 : 32'd42);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("cont_idle", busy, 0);

    // Backpressure: result held for 5 cycles with rsp0_ready low
    rsp0_ready = 1'b0;
    set_req0(1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
    #1;
    check("bp_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    set_req1(1'b1, 32'd2, 32'd2, 3'b000);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_rsp0_valid", k), rsp0_valid, 1);
      check($sformatf("bp%0d_result", k), rsp0_result, 32'h0000_00FF);
      check($sformatf("bp%0d_readies", k), {req0_ready, req1_ready}, 0);
      if (k < 4) tick();
    end
    rsp0_ready = 1'b1;
    tick();
    check("bp_done_busy", busy, 0);
    check("bp_done_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    tick();
    check("bp_no_accept", busy, 0);

    // Arithmetic shift right
    set_req0(1'b1, 32'h8000_0000, 32'd4, 3'b111);
    #1;
    check("sra_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("sra_rsp0_valid", rsp0_valid, 1);
    check("sra_result", rsp0_result, 32'hF800_0000);
    tick();

    // Reset while in EXEC aborts the operation
    set_req0(1'b1, 32'd1, 32'd2, 3'b000);
    tick();
    req0_valid = 1'b0;
    check("abort_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_alu_a", alu_a, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort%0d_no_rsp", k), {rsp0_valid, rsp1_valid, busy}, 0);
      tick();
    end
    set_req0(1'b1, 32'd9, 32'd6, 3'b001);
    #1;
    check("post_abort_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    check("post_abort_rsp0_valid", rsp0_valid, 1);
    check("post_abort_result", rsp0_result, 32'd3);
    tick();
    check("post_abort_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
